// File: rtl/game_pkg.sv
// Shared state encoding for the game controller and board datapath.
// Provides STATE_W and the state_e enum (IDLE..LOSE, codes 0..7).
package game_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 3'd0,
    S_SET_BOARD = 3'd1,
    S_SET_DIFF  = 3'd2,
    S_PLAY      = 3'd3,
    S_CHECKING  = 3'd4,
    S_WIN       = 3'd5,
    S_TRY_AGAIN = 3'd6,
    S_LOSE      = 3'd7
  } state_e;

endpackage

// File: rtl/game_ctrl_fsm_if.sv
// Controller <-> datapath link: generator status and check handshake.
// master (controller): drives check_req; slave (datapath): the rest.
interface game_ctrl_fsm_if;

  logic gen_done;
  logic check_req;
  logic check_done;
  logic solved;

  modport master (
    input  gen_done,
    input  check_done,
    input  solved,
    output check_req
  );

  modport slave (
    output gen_done,
    output check_done,
    output solved,
    input  check_req
  );

endinterface

// File: rtl/game_ctrl_fsm_btn_edge.sv
// One-bit rising-edge detector; history resets to 1 so a held button
// gives no edge. Ports: clka, restart, btn in; rise out.
module btn_edge (
  input  logic clka,
  input  logic restart,
  input  logic btn,
  output logic rise
);

  logic hist_q;
  logic hist_d;

  assign hist_d = btn;
  assign rise   = btn & ~hist_q;

  always_ff @(posedge clka) begin
    if (restart) hist_q <= 1'b1;
    else         hist_q <= hist_d;
  end

endmodule

// File: rtl/game_ctrl_fsm.sv
// Game top-level controller: buttons/switches in, mode flags, state code,
// difficulty, tries and check handshake (dp) out. Sync reset: restart.
module game_ctrl_fsm
  import game_pkg::*;
#(
  parameter int DIFF_LEVELS   = 4,
  parameter int DIFF_W        = 2,
  parameter int MAX_TRIES     = 3,
  parameter int TRY_W         = 2,
  parameter int CHECK_TIMEOUT = 64,
  parameter int TMO_W         = 7
) (
  input  logic              clka,
  input  logic              restart,
  input  logic              enter,
  input  logic              check,
  input  logic              up,
  game_ctrl_fsm_if.master   dp,
  output logic [STATE_W-1:0] state,
  output logic              gen_rand_flag,
  output logic              set_board_flag,
  output logic              set_diff_flag,
  output logic              play_flag,
  output logic              check_flag,
  output logic              win_flag,
  output logic              try_again_flag,
  output logic              lose_flag,
  output logic [DIFF_W-1:0] diff_level,
  output logic [TRY_W-1:0]  tries_left,
  output logic              timeout_flag
);

  localparam logic [DIFF_W-1:0] DIFF_MAX = DIFF_W'(DIFF_LEVELS - 1);
  localparam logic [TRY_W-1:0]  TRY_INIT = TRY_W'(MAX_TRIES);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(CHECK_TIMEOUT - 1);
  localparam bit                LIMITED  = (MAX_TRIES != 0);

  logic enter_rise;
  logic check_rise;
  logic up_rise;

  btn_edge u_enter (
    .clka(clka), .restart(restart), .btn(enter), .rise(enter_rise)
  );
  btn_edge u_check (
    .clka(clka), .restart(restart), .btn(check), .rise(check_rise)
  );
  btn_edge u_up (
    .clka(clka), .restart(restart), .btn(up), .rise(up_rise)
  );

  state_e            state_q, state_d;
  logic [DIFF_W-1:0] diff_q, diff_d;
  logic [TRY_W-1:0]  tries_q, tries_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              tflag_q, tflag_d;
  logic              creq_q, creq_d;

  always_comb begin
    state_d = state_q;
    diff_d  = diff_q;
    tries_d = tries_q;
    tmo_d   = tmo_q;
    tflag_d = tflag_q;
    creq_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enter_rise) begin
          state_d = S_SET_BOARD;
          tflag_d = 1'b0;
        end
      end
      S_SET_BOARD: begin
        if (enter_rise && dp.gen_done) state_d = S_SET_DIFF;
      end
      S_SET_DIFF: begin
        if (up_rise) begin
          diff_d = (diff_q == DIFF_MAX) ? '0 : diff_q + DIFF_W'(1);
        end
        if (enter_rise) begin
          state_d = S_PLAY;
          tries_d = TRY_INIT;
        end
      end
      S_PLAY: begin
        if (check_rise) begin
          state_d = S_CHECKING;
          creq_d  = 1'b1;
          tmo_d   = '0;
        end
      end
      S_CHECKING: begin
        tmo_d = tmo_q + TMO_W'(1);
        // A result on the expiry cycle takes priority over the abort.
        if (dp.check_done) begin
          if (dp.solved) begin
            state_d = S_WIN;
          end else if (LIMITED && tries_q == TRY_W'(1)) begin
            tries_d = '0;
            state_d = S_LOSE;
          end else begin
            if (LIMITED) tries_d = tries_q - TRY_W'(1);
            state_d = S_TRY_AGAIN;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_TRY_AGAIN;
          tflag_d = 1'b1;
        end
      end
      S_TRY_AGAIN: begin
        if (enter_rise) state_d = S_PLAY;
      end
      S_WIN, S_LOSE: begin
        if (enter_rise) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (restart) begin
      state_q <= S_IDLE;
      diff_q  <= '0;
      tries_q <= TRY_INIT;
      tmo_q   <= '0;
      tflag_q <= 1'b0;
      creq_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      diff_q  <= diff_d;
      tries_q <= tries_d;
      tmo_q   <= tmo_d;
      tflag_q <= tflag_d;
      creq_q  <= creq_d;
    end
  end

  always_comb begin
    gen_rand_flag  = 1'b0;
    set_board_flag = 1'b0;
    set_diff_flag  = 1'b0;
    play_flag      = 1'b0;
    check_flag     = 1'b0;
    win_flag       = 1'b0;
    try_again_flag = 1'b0;
    lose_flag      = 1'b0;
    unique case (state_q)
      S_IDLE:      gen_rand_flag  = 1'b1;
      S_SET_BOARD: set_board_flag = 1'b1;
      S_SET_DIFF:  set_diff_flag  = 1'b1;
      S_PLAY: begin
        gen_rand_flag = 1'b1;
        play_flag     = 1'b1;
      end
      S_CHECKING:  check_flag     = 1'b1;
      S_WIN:       win_flag       = 1'b1;
      S_TRY_AGAIN: try_again_flag = 1'b1;
      S_LOSE:      lose_flag      = 1'b1;
      default:     gen_rand_flag  = 1'b1;
    endcase
  end

  assign state        = state_q;
  assign diff_level   = diff_q;
  assign tries_left   = tries_q;
  assign timeout_flag = tflag_q;
  assign dp.check_req = creq_q;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Scoreboard bench: two controllers (MAX_TRIES 3 and 0) share stimulus;
// a rule-level game model predicts every output change and its cycle.
module tb_game_ctrl_fsm;

  localparam int TMO = 64;
  localparam int LV  = 4;

  logic clka = 1'b0;
  logic restart = 1'b1;
  logic enter = 1'b1;
  logic check = 1'b0;
  logic up = 1'b0;
  logic gen_done = 1'b0;
  logic check_done = 1'b0;
  logic solved = 1'b0;

  always #5 clka = ~clka;

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  logic [2:0] st [2];
  logic [1:0] dl [2];
  logic [1:0] tl [2];
  logic       tf [2];
  logic       cr [2];
  logic [7:0] fl [2];

  for (genvar g = 0; g < 2; g++) begin : gd
    game_ctrl_fsm_if ifc ();
    logic [2:0] s_w;
    logic [1:0] d_w, t_w;
    logic       tf_w;
    logic [7:0] f;
    assign ifc.gen_done   = gen_done;
    assign ifc.check_done = check_done;
    assign ifc.solved     = solved;
    game_ctrl_fsm #(
      .DIFF_LEVELS(LV), .DIFF_W(2),
      .MAX_TRIES(g == 0 ? 3 : 0), .TRY_W(2),
      .CHECK_TIMEOUT(TMO), .TMO_W(7)
    ) dut (
      .clka(clka), .restart(restart),
      .enter(enter), .check(check), .up(up),
      .dp(ifc),
      .state(s_w),
      .gen_rand_flag(f[7]), .set_board_flag(f[6]),
      .set_diff_flag(f[5]), .play_flag(f[4]),
      .check_flag(f[3]), .win_flag(f[2]),
      .try_again_flag(f[1]), .lose_flag(f[0]),
      .diff_level(d_w), .tries_left(t_w),
      .timeout_flag(tf_w)
    );
    assign st[g] = s_w;
    assign dl[g] = d_w;
    assign tl[g] = t_w;
    assign tf[g] = tf_w;
    assign cr[g] = ifc.check_req;
    assign fl[g] = f;
  end

  typedef struct {
    int cyc; int st; int dl; int tl; int tf; int cr;
  } rec_t;

  rec_t m [2];
  rec_t prv [2];
  rec_t q0 [$];
  rec_t q1 [$];
  rec_t a_r, e_r;
  int   chk_start [2];
  int   errs = 0;
  int   checks = 0;
  int   snap_req = 0;
  int   snap_ack = 0;
  bit   mon_en = 0;
  bit   fin_req = 0;
  bit   fin_ack = 0;

  function automatic int maxt(int g);
    return (g == 0) ? 3 : 0;
  endfunction

  function automatic logic [7:0] dec(int s);
    case (s)
      0: return 8'h80;
      1: return 8'h40;
      2: return 8'h20;
      3: return 8'h90;
      4: return 8'h08;
      5: return 8'h04;
      6: return 8'h02;
      7: return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit same(rec_t a, rec_t b);
    return a.st == b.st && a.dl == b.dl && a.tl == b.tl &&
           a.tf == b.tf && a.cr == b.cr;
  endfunction

  function automatic rec_t act(int g);
    rec_t r;
    r.cyc = cyc;
    r.st  = int'(st[g]);
    r.dl  = int'(dl[g]);
    r.tl  = int'(tl[g]);
    r.tf  = int'(tf[g]);
    r.cr  = int'(cr[g]);
    return r;
  endfunction

  always @(negedge clka) begin
    if (mon_en) begin
      for (int g = 0; g < 2; g++) begin
        a_r = act(g);
        if (snap_req != snap_ack) begin
          checks++;
          if (!same(a_r, m[g]) || fl[g] != dec(m[g].st)) begin
            errs++;
            $display("FAIL snap dut%0d @%0d: got st=%0d dl=%0d tl=%0d tf=%0d cr=%0d fl=%h, need st=%0d dl=%0d tl=%0d tf=%0d cr=%0d fl=%h",
              g, cyc, a_r.st, a_r.dl, a_r.tl, a_r.tf, a_r.cr, fl[g],
              m[g].st, m[g].dl, m[g].tl, m[g].tf, m[g].cr, dec(m[g].st));
          end
          prv[g] = a_r;
        end else if (!same(a_r, prv[g])) begin
          checks++;
          if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
            errs++;
            $display("FAIL unexpected dut%0d @%0d: got st=%0d dl=%0d tl=%0d tf=%0d cr=%0d, need no change",
              g, cyc, a_r.st, a_r.dl, a_r.tl, a_r.tf, a_r.cr);
          end else begin
            if (g == 0) e_r = q0.pop_front();
            else        e_r = q1.pop_front();
            if (!same(a_r, e_r) || a_r.cyc != e_r.cyc ||
                fl[g] != dec(e_r.st)) begin
              errs++;
              $display("FAIL event dut%0d: got @%0d st=%0d dl=%0d tl=%0d tf=%0d cr=%0d fl=%h, need @%0d st=%0d dl=%0d tl=%0d tf=%0d cr=%0d fl=%h",
                g, a_r.cyc, a_r.st, a_r.dl, a_r.tl, a_r.tf, a_r.cr, fl[g],
                e_r.cyc, e_r.st, e_r.dl, e_r.tl, e_r.tf, e_r.cr, dec(e_r.st));
            end
          end
          prv[g] = a_r;
        end
      end
      if (snap_req != snap_ack) snap_ack = snap_req;
      if (fin_req && !fin_ack) begin
        checks++;
        if (q0.size() != 0) begin
          errs++;
          $display("FAIL missing dut0: got %0d pending, need 0 (next @%0d st=%0d)",
            q0.size(), q0[0].cyc, q0[0].st);
        end
        checks++;
        if (q1.size() != 0) begin
          errs++;
          $display("FAIL missing dut1: got %0d pending, need 0 (next @%0d st=%0d)",
            q1.size(), q1[0].cyc, q1[0].st);
        end
        fin_ack = 1;
      end
    end
  end

  function automatic void push(int g, rec_t r);
    if (same(r, m[g])) return;
    m[g] = r;
    if (g == 0) begin
      if (q0.size() > 0 && q0[$].cyc == r.cyc) q0[$] = r;
      else q0.push_back(r);
    end else begin
      if (q1.size() > 0 && q1[$].cyc == r.cyc) q1[$] = r;
      else q1.push_back(r);
    end
  endfunction

  function automatic rec_t reset_rec(int g, int t);
    rec_t r;
    r.cyc = t; r.st = 0; r.dl = 0; r.tl = maxt(g); r.tf = 0; r.cr = 0;
    return r;
  endfunction

  // which: 0 = enter, 1 = up, 2 = check
  function automatic void model_btn(int g, int which, int t);
    rec_t r;
    r = m[g];
    r.cyc = t;
    if (which == 0) begin
      case (r.st)
        0: begin r.st = 1; r.tf = 0; end
        1: if (gen_done) r.st = 2;
        2: begin r.st = 3; r.tl = maxt(g); end
        6: r.st = 3;
        5, 7: r.st = 0;
        default: ;
      endcase
    end else if (which == 1) begin
      if (r.st == 2) r.dl = (r.dl + 1) % LV;
    end else if (r.st == 3) begin
      r.st = 4;
      r.cr = 1;
      push(g, r);
      chk_start[g] = t;
      r.cyc = t + 1;
      r.cr = 0;
    end
    push(g, r);
  endfunction

  task automatic press(int which);
    @(negedge clka);
    if (which == 0) enter = 1'b1;
    else if (which == 1) up = 1'b1;
    else check = 1'b1;
    for (int g = 0; g < 2; g++) model_btn(g, which, cyc + 1);
    @(negedge clka);
    enter = 1'b0;
    up = 1'b0;
    check = 1'b0;
  endtask

  // Called straight after press(2): answer k cycles into CHECKING.
  task automatic respond(int k, bit s);
    rec_t r;
    int dn;
    dn = cyc + k;
    for (int g = 0; g < 2; g++) begin
      if (m[g].st == 4) begin
        r = m[g];
        r.cr = 0;
        if (dn - chk_start[g] <= TMO - 1) begin
          r.cyc = dn + 1;
          if (s) r.st = 5;
          else if (maxt(g) != 0 && r.tl == 1) begin
            r.tl = 0;
            r.st = 7;
          end else begin
            if (maxt(g) != 0) r.tl = r.tl - 1;
            r.st = 6;
          end
        end else begin
          r.cyc = chk_start[g] + TMO;
          r.st = 6;
          r.tf = 1;
        end
        push(g, r);
      end
    end
    repeat (k) @(negedge clka);
    check_done = 1'b1;
    solved = s;
    @(negedge clka);
    check_done = 1'b0;
    solved = 1'b0;
  endtask

  task automatic do_restart(bit dn);
    @(negedge clka);
    restart = 1'b1;
    check_done = dn;
    solved = dn;
    for (int g = 0; g < 2; g++) push(g, reset_rec(g, cyc + 1));
    @(negedge clka);
    restart = 1'b0;
    check_done = 1'b0;
    solved = 1'b0;
  endtask

  task automatic snap();
    repeat (2) @(negedge clka);
    snap_req++;
    repeat (2) @(negedge clka);
  endtask

  task automatic to_play();
    gen_done = 1'b1;
    press(0);
    press(0);
    press(0);
  endtask

  initial begin
    repeat (3) @(negedge clka);
    for (int g = 0; g < 2; g++) m[g] = reset_rec(g, cyc);
    mon_en = 1;
    snap_req++;
    @(negedge clka);
    restart = 1'b0;
    repeat (5) @(negedge clka);
    enter = 1'b0;
    repeat (2) @(negedge clka);
    press(0);
    snap();

    gen_done = 1'b0;
    press(0);
    gen_done = 1'b1;
    press(0);
    repeat (5) press(1);
    press(0);
    snap();

    repeat (3) begin
      press(2);
      respond($urandom_range(1, 20), 1'b0);
      snap();
      press(0);
    end
    snap();
    do_restart(1'b0);
    snap();

    to_play();
    press(2);
    respond(70, 1'b1);
    snap();
    press(0);
    press(2);
    respond(5, 1'b1);
    press(0);
    snap();
    press(0);
    snap();

    press(0);
    press(0);
    press(2);
    respond(TMO - 1, 1'b1);
    snap();
    press(0);
    snap();
    to_play();
    press(2);
    respond(TMO, 1'b1);
    snap();
    press(0);

    press(2);
    repeat (3) @(negedge clka);
    do_restart(1'b1);
    snap();

    repeat (80) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 3) press(0);
      else if (r <= 5) press(1);
      else if (r <= 7) begin
        press(2);
        respond($urandom_range(0, 70), 1'($urandom_range(0, 1)));
      end else if (r == 8) begin
        @(negedge clka);
        gen_done = 1'($urandom_range(0, 1));
      end else do_restart(1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clka);
    end
    snap();

    repeat (3) @(negedge clka);
    fin_req = 1;
    for (int i = 0; i < 10 && !fin_ack; i++) @(negedge clka);
    if (!fin_ack) begin
      $display("FAIL final: got no monitor ack, need ack within 10 cycles");
      $fatal(1);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
